// File: rtl/spc_stack_ctl.sv
// SPC subroutine-stack sequencer: microcode push/pop/replace, spco refresh, depth/flags, halted debug access.
// Latency: uc op 1 cycle + 1 refresh cycle; debug ack 2 cycles after accept. No backpressure: microcode must not step while busy.
// Optional SPC_STACK_CTL_TRAP_EN: suppress overflowing push / underflowing pop and pulse spc_trap.
module spc_stack_ctl #(
   parameter int PTR_BITS   = 5,
   parameter int DATA_WIDTH = 19
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  state_fetch,
   input  logic                  uc_push,
   input  logic                  uc_pop,
   input  logic [DATA_WIDTH-1:0] uc_data,
   input  logic                  uc_halt,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [DATA_WIDTH-1:0] dbg_wdata,
   output logic                  dbg_ack,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   input  logic [DATA_WIDTH-1:0] spco,
   output logic [DATA_WIDTH-1:0] spcw,
   output logic                  spcnt,
   output logic                  spush,
   output logic                  swp,
   output logic                  srp,
   output logic [PTR_BITS:0]     depth,
   output logic                  spc_ovf,
   output logic                  spc_unf,
   input  logic                  err_clr
`ifdef SPC_STACK_CTL_TRAP_EN
   ,
   output logic                  spc_trap
`endif
);

`ifdef SPC_STACK_CTL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   localparam logic [PTR_BITS:0] DEPTH_MAX = {1'b1, {PTR_BITS{1'b0}}};
   localparam logic [PTR_BITS:0] DEPTH_ONE = {{PTR_BITS{1'b0}}, 1'b1};

   typedef enum logic [2:0] {IDLE, REFRESH, DBG_RD, DBG_WR, DBG_ACK} state_t;

   state_t                state_q, state_d;
   logic [PTR_BITS:0]     depth_q, depth_d;
   logic                  ovf_q, unf_q, ovf_set, unf_set;
   logic                  dbg_rd_q, dbg_rd_d;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  spcnt_c, spush_c, swp_c, srp_c, ack_c;
   logic                  is_full, is_empty, idle_op, trap_hit, rd_ack;

   assign is_full  = (depth_q == DEPTH_MAX);
   assign is_empty = (depth_q == '0);
   assign idle_op  = (state_q == IDLE) && state_fetch && (uc_push || uc_pop);
   // Only a lone push at full or a lone pop at empty can trap; replace always proceeds.
   assign trap_hit = TRAP_EN && idle_op && (uc_push != uc_pop) && (uc_push ? is_full : is_empty);
   assign rd_ack   = (state_q == DBG_ACK) && dbg_rd_q;

   always_comb begin
      state_d  = state_q;
      depth_d  = depth_q;
      dbg_rd_d = dbg_rd_q;
      ovf_set  = 1'b0;
      unf_set  = 1'b0;
      spcnt_c  = 1'b0;
      spush_c  = 1'b0;
      swp_c    = 1'b0;
      srp_c    = 1'b0;
      ack_c    = 1'b0;
      spcw     = uc_data;
      case (state_q)
         IDLE: begin
            if (idle_op) begin
               state_d = REFRESH;
               if (uc_push && uc_pop) begin
                  swp_c   = 1'b1;
                  unf_set = is_empty;
               end else if (uc_push) begin
                  ovf_set = is_full;
                  if (trap_hit) begin
                     state_d = IDLE;
                  end else begin
                     spcnt_c = 1'b1;
                     spush_c = 1'b1;
                     swp_c   = 1'b1;
                     if (!is_full) depth_d = depth_q + DEPTH_ONE;
                  end
               end else begin
                  unf_set = is_empty;
                  if (trap_hit) begin
                     state_d = IDLE;
                  end else begin
                     spcnt_c = 1'b1;
                     if (!is_empty) depth_d = depth_q - DEPTH_ONE;
                  end
               end
            end else if (!state_fetch && uc_halt && dbg_req) begin
               state_d  = dbg_we ? DBG_WR : DBG_RD;
               dbg_rd_d = !dbg_we;
            end
         end
         REFRESH: begin
            srp_c   = 1'b1;
            state_d = IDLE;
         end
         DBG_RD: begin
            srp_c   = 1'b1;
            state_d = DBG_ACK;
         end
         DBG_WR: begin
            swp_c   = 1'b1;
            spcw    = dbg_wdata;
            state_d = DBG_ACK;
         end
         DBG_ACK: begin
            ack_c   = 1'b1;
            srp_c   = !dbg_rd_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Strobes are forced low while reset is held so an aborted operation never completes.
   assign spcnt     = spcnt_c & ~reset;
   assign spush     = spush_c & ~reset;
   assign swp       = swp_c & ~reset;
   assign srp       = srp_c & ~reset;
   assign dbg_ack   = ack_c & ~reset;
   assign dbg_rdata = rd_ack ? spco : rdata_q;
   assign depth     = depth_q;
   assign spc_ovf   = ovf_q;
   assign spc_unf   = unf_q;
`ifdef SPC_STACK_CTL_TRAP_EN
   assign spc_trap  = trap_hit & ~reset;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         depth_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         dbg_rd_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         depth_q  <= depth_d;
         dbg_rd_q <= dbg_rd_d;
         ovf_q    <= ovf_set | (ovf_q & ~err_clr);
         unf_q    <= unf_set | (unf_q & ~err_clr);
         if (rd_ack) rdata_q <= spco;
      end
   end

endmodule
